b1_sync_fifo: RTL and testbench
===============================

Name: b1_sync_fifo

Overview:
- Single-clock FIFO, drop-in behavioural equivalent of the vendor scfifo: legacy mode, overflow and underflow checking on, no almost-flags.
- Used wherever a portable FIFO must match the vendor macro cycle for cycle on empty_o, full_o, q_o and usedw_o.
- Storage is 2**AWIDTH words of DWIDTH bits in an inferred RAM or register array.

Parameters:
- DWIDTH, 8, data word width in bits.
- AWIDTH, 8, address width; depth = 2**AWIDTH words.
- SHOWAHEAD, "ON", "ON" = look-ahead (head word visible on q_o); "OFF" = normal mode (q_o updated after a read request).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- srst_i  in  1  synchronous reset, active-low; sampled on the rising edge.
- wrreq_i  in  1  write request.
- rdreq_i  in  1  read request (acknowledge in showahead mode).
- data_i  in  DWIDTH  write data.
- q_o  out  DWIDTH  read data.
- empty_o  out  1  FIFO holds 0 words.
- full_o  out  1  FIFO holds 2**AWIDTH words.
- usedw_o  out  AWIDTH  word count modulo 2**AWIDTH (reads 0 when full).

Behaviour:
- Reset (srst_i=0 at an edge): pointers=0, count=0, empty_o=1, full_o=0, usedw_o=0, q_o=0. Reset has priority over any request in the same cycle. RAM contents are not cleared.
- Write acceptance: wr_en = wrreq_i & ~full_o. A write while full is dropped, even if a read is accepted in the same cycle.
- Read acceptance: rd_en = rdreq_i & ~empty_o. A read while empty is ignored, even if a write is accepted in the same cycle.
- Count update:
  - wr_en & ~rd_en: count+1.
  - rd_en & ~wr_en: count-1.
  - Both or neither: count unchanged.
- Count is held internally as AWIDTH+1 bits.
- empty_o, full_o and usedw_o are registered and reflect the count after the edge. Latency is 1 clock from the accepted request.
- full_o = (count == 2**AWIDTH). empty_o = (count == 0). usedw_o = count[AWIDTH-1:0].
- Write and read pointers are AWIDTH bits and wrap naturally from 2**AWIDTH-1 to 0.
- Simultaneous read and write at any fill level 1..2**AWIDTH-1: both pointers advance and ordering is preserved.
- SHOWAHEAD="ON":
  - q_o is registered and, after every edge, equals the word at the head of the FIFO whenever empty_o=0.
  - A write into an empty FIFO makes that word appear on q_o in the same cycle empty_o falls.
  - rd_en pops the head; on the next edge q_o shows the following word.
  - When the FIFO becomes empty, q_o holds its last value.
  - The head-word bypass must cover a write and a read to the same address in one cycle.
- SHOWAHEAD="OFF": on rd_en, q_o <= mem[rd_ptr] at that edge (1-cycle latency). Otherwise q_o holds its value.
- Reset mid-operation discards all contents. The first post-reset write behaves as a write into an empty FIFO.

Optional Feature:
- Macro B1_SYNC_FIFO_ERR_FLAGS_EN.
- When defined, adds two ports:
  - ovf_o (out, 1): sticky, set at the edge where wrreq_i=1 & full_o=1.
  - udf_o (out, 1): sticky, set at the edge where rdreq_i=1 & empty_o=1.
- Both flags clear only on reset (value 0).
- When undefined, the ports and logic are absent; the dropped-request behaviour is unchanged.

Test Plan:
- Reset then idle -> empty_o=1, full_o=0, usedw_o=0, q_o=0 on every cycle.
- Single write of 0xA5 into an empty FIFO (SHOWAHEAD="ON") -> next cycle empty_o=0, usedw_o=1, q_o=0xA5. One rdreq -> next cycle empty_o=1, usedw_o=0.
- Write 256 consecutive words 0..255 (AWIDTH=8) -> after the last edge full_o=1, usedw_o=0. A 257th wrreq is dropped and usedw_o stays 0. Reading all 256 returns 0..255 in order with q_o matching before each acknowledge, then empty_o=1.
- Fill to 100 words, then assert wrreq_i and rdreq_i together for 300 cycles -> usedw_o stays 100 and data order is preserved across pointer wrap.
- Random traffic over 2048 cycles (write probability 2/3, read probability 1/2, then swapped) -> every cycle empty_o, full_o, q_o and usedw_o match a behavioural scfifo reference model.
- Assert srst_i=0 at 50 words stored -> next cycle usedw_o=0, empty_o=1. A following write/read returns the new data. With B1_SYNC_FIFO_ERR_FLAGS_EN, rdreq on empty sets udf_o=1, and it stays 1 until reset.

Source files
------------

// File: rtl/b1_sync_fifo.sv
// Single-clock FIFO, cycle-equivalent to the vendor scfifo in legacy mode with
// overflow/underflow protection. Define B1_SYNC_FIFO_ERR_FLAGS_EN to add sticky ovf_o/udf_o.
module b1_sync_fifo #(
   parameter int    DWIDTH    = 8,
   parameter int    AWIDTH    = 8,
   parameter string SHOWAHEAD = "ON"
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              wrreq_i,
   input  logic              rdreq_i,
   input  logic [DWIDTH-1:0] data_i,
   output logic [DWIDTH-1:0] q_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [AWIDTH-1:0] usedw_o
`ifdef B1_SYNC_FIFO_ERR_FLAGS_EN
   ,
   output logic              ovf_o,
   output logic              udf_o
`endif
);

   localparam int              DEPTH      = 2**AWIDTH;
   localparam bit              SHOW_AHEAD = (SHOWAHEAD == "ON");
   localparam logic [AWIDTH:0]   CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};
   localparam logic [AWIDTH:0]   CNT_FULL = {1'b1, {AWIDTH{1'b0}}};
   localparam logic [AWIDTH-1:0] PTR_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};

   logic [DWIDTH-1:0] mem [DEPTH];

   logic [AWIDTH-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AWIDTH-1:0] rd_ptr_reg, rd_ptr_next;
   logic [AWIDTH:0]   count_reg,  count_next;
   logic              empty_reg;
   logic              full_reg;
   logic [AWIDTH-1:0] usedw_reg;
   logic [DWIDTH-1:0] q_reg;
   logic              wr_en;
   logic              rd_en;

   // Requests are qualified by the registered flags, so a full FIFO drops writes
   // even when a read is accepted in the same cycle (and likewise for empty).
   assign wr_en = wrreq_i & ~full_reg;
   assign rd_en = rdreq_i & ~empty_reg;

   always_comb begin
      wr_ptr_next = wr_ptr_reg + (wr_en ? PTR_ONE : '0);
      rd_ptr_next = rd_ptr_reg + (rd_en ? PTR_ONE : '0);
      count_next  = count_reg;
      case ({wr_en, rd_en})
         2'b10:   count_next = count_reg + CNT_ONE;
         2'b01:   count_next = count_reg - CNT_ONE;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i && wr_en) begin
         mem[wr_ptr_reg] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!srst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         empty_reg  <= 1'b1;
         full_reg   <= 1'b0;
         usedw_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         empty_reg  <= (count_next == '0);
         full_reg   <= (count_next == CNT_FULL);
         usedw_reg  <= count_next[AWIDTH-1:0];
      end
   end

   generate
      if (SHOW_AHEAD) begin : g_showahead
         logic [DWIDTH-1:0] head_word;

         // The next head is the word just being written when it lands at the
         // post-edge read address (write into empty, or write+read at count 1).
         assign head_word = (wr_en && (wr_ptr_reg == rd_ptr_next)) ? data_i
                                                                   : mem[rd_ptr_next];

         always_ff @(posedge clk_i) begin
            if (!srst_i) begin
               q_reg <= '0;
            end else if (count_next != '0) begin
               q_reg <= head_word;
            end
         end
      end else begin : g_normal
         always_ff @(posedge clk_i) begin
            if (!srst_i) begin
               q_reg <= '0;
            end else if (rd_en) begin
               q_reg <= mem[rd_ptr_reg];
            end
         end
      end
   endgenerate

`ifdef B1_SYNC_FIFO_ERR_FLAGS_EN
   logic ovf_reg;
   logic udf_reg;

   // Sticky until reset; raised by the raw request, not the qualified enable.
   always_ff @(posedge clk_i) begin
      if (!srst_i) begin
         ovf_reg <= 1'b0;
         udf_reg <= 1'b0;
      end else begin
         if (wrreq_i && full_reg) begin
            ovf_reg <= 1'b1;
         end
         if (rdreq_i && empty_reg) begin
            udf_reg <= 1'b1;
         end
      end
   end

   assign ovf_o = ovf_reg;
   assign udf_o = udf_reg;
`endif

   assign q_o     = q_reg;
   assign empty_o = empty_reg;
   assign full_o  = full_reg;
   assign usedw_o = usedw_reg;

endmodule

// File: tb/tb_b1_sync_fifo.sv
// Self-checking bench for b1_sync_fifo (DWIDTH=8, AWIDTH=8, SHOWAHEAD="ON"):
// vector table plus scoreboard-backed multi-cycle sequences.
module tb_b1_sync_fifo;

   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          srst;
   logic          wrreq;
   logic          rdreq;
   logic [DW-1:0] data;
   logic [DW-1:0] q;
   logic          empty;
   logic          full;
   logic [AW-1:0] usedw;
`ifdef B1_SYNC_FIFO_ERR_FLAGS_EN
   logic          ovf;
   logic          udf;
`endif

   always #5 clk = ~clk;

   b1_sync_fifo #(
      .DWIDTH   (DW),
      .AWIDTH   (AW),
      .SHOWAHEAD("ON")
   ) dut (
      .clk_i  (clk),
      .srst_i (srst),
      .wrreq_i(wrreq),
      .rdreq_i(rdreq),
      .data_i (data),
      .q_o    (q),
      .empty_o(empty),
      .full_o (full),
      .usedw_o(usedw)
`ifdef B1_SYNC_FIFO_ERR_FLAGS_EN
      ,
      .ovf_o  (ovf),
      .udf_o  (udf)
`endif
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] sb[$];
   logic [DW-1:0] model_q = '0;
   logic          m_ovf = 1'b0;
   logic          m_udf = 1'b0;

   typedef struct {
      logic          rst_n;
      logic          wr;
      logic          rd;
      logic [DW-1:0] d;
      logic          e;
      logic          f;
      logic [AW-1:0] u;
      logic [DW-1:0] qq;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the reference model, compare after the edge.
   task automatic step(input logic rst_n, input logic wr, input logic rd, input logic [DW-1:0] d);
      logic          acc_wr;
      logic          acc_rd;
      logic [DW-1:0] popped;
      srst   = rst_n;
      wrreq  = wr;
      rdreq  = rd;
      data   = d;
      acc_wr = wr && (sb.size() < DEPTH);
      acc_rd = rd && (sb.size() > 0);
      if (!rst_n) begin
         sb.delete();
         model_q = '0;
         m_ovf   = 1'b0;
         m_udf   = 1'b0;
      end else begin
         if (wr && sb.size() == DEPTH) m_ovf = 1'b1;
         if (rd && sb.size() == 0)     m_udf = 1'b1;
         if (acc_rd) begin
            popped = sb.pop_front();
            check("rd_data", 32'(q), 32'(popped));
         end
         if (acc_wr) sb.push_back(d);
         if (sb.size() > 0) model_q = sb[0];
      end
      @(posedge clk);
      #1;
      check("empty", 32'(empty), 32'(sb.size() == 0));
      check("full",  32'(full),  32'(sb.size() == DEPTH));
      check("usedw", 32'(usedw), 32'(sb.size() % DEPTH));
      check("q",     32'(q),     32'(model_q));
`ifdef B1_SYNC_FIFO_ERR_FLAGS_EN
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("udf", 32'(udf), 32'(m_udf));
`endif
   endtask

   initial begin
      srst  = 1'b0;
      wrreq = 1'b0;
      rdreq = 1'b0;
      data  = '0;

      //          rst  wr    rd    d      empty full  usedw  q
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 8'h00};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 8'h00};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 8'h00};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'd1, 8'hA5};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd0, 8'hA5};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd0, 8'hA5};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'd1, 8'h3C};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 8'd2, 8'h3C};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'd2, 8'h77};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd1, 8'h11};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 8'd1, 8'h22};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd0, 8'h22};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 8'd1, 8'h99};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 8'd0, 8'h00};

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].rst_n, tbl[i].wr, tbl[i].rd, tbl[i].d);
         check("vec_empty", 32'(empty), 32'(tbl[i].e));
         check("vec_full",  32'(full),  32'(tbl[i].f));
         check("vec_usedw", 32'(usedw), 32'(tbl[i].u));
         check("vec_q",     32'(q),     32'(tbl[i].qq));
         $display("vec %0d: rst_n=%b wr=%b rd=%b d=%02h -> empty=%b full=%b usedw=%0d q=%02h",
                  i, tbl[i].rst_n, tbl[i].wr, tbl[i].rd, tbl[i].d, empty, full, usedw, q);
      end

      // Fill to full, drop one write, drain in order.
      step(1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 8'(i));
      check("fill_full", 32'(full), 32'd1);
      check("fill_usedw", 32'(usedw), 32'd0);
      step(1'b1, 1'b1, 1'b0, 8'hEE);
      check("drop_usedw", 32'(usedw), 32'd0);
      check("drop_full", 32'(full), 32'd1);
`ifdef B1_SYNC_FIFO_ERR_FLAGS_EN
      check("ovf_set", 32'(ovf), 32'd1);
`endif
      for (int i = 0; i < DEPTH; i++) begin
         check("drain_head", 32'(q), 32'(i));
         step(1'b1, 1'b0, 1'b1, '0);
      end
      check("drain_empty", 32'(empty), 32'd1);
      $display("seq fill/drain: %0d words, empty=%b", DEPTH, empty);

      // Steady 100-word occupancy with concurrent read/write across pointer wrap.
      step(1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom));
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'b1, 1'b1, 8'($urandom));
         check("steady_usedw", 32'(usedw), 32'd100);
      end
      $display("seq steady: usedw=%0d after 300 concurrent cycles", usedw);

      // Random traffic, write-heavy then read-heavy.
      step(1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 2048; i++) begin
         if (i < 1024) step(1'b1, 1'($urandom_range(2, 0) != 0), 1'($urandom_range(1, 0)), 8'($urandom));
         else          step(1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(2, 0) != 0), 8'($urandom));
      end
      $display("seq random: 2048 cycles, final usedw=%0d", usedw);

      // Reset mid-operation, then fresh data and underflow.
      step(1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 50; i++) step(1'b1, 1'b1, 1'b0, 8'(i + 7));
      step(1'b0, 1'b0, 1'b0, '0);
      check("rst_usedw", 32'(usedw), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      step(1'b1, 1'b1, 1'b0, 8'h5A);
      check("post_rst_q", 32'(q), 32'h5A);
      step(1'b1, 1'b0, 1'b1, '0);
      check("post_rst_empty", 32'(empty), 32'd1);
      step(1'b1, 1'b0, 1'b1, '0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
`ifdef B1_SYNC_FIFO_ERR_FLAGS_EN
      check("udf_sticky", 32'(udf), 32'd1);
      step(1'b0, 1'b0, 1'b0, '0);
      check("udf_clear", 32'(udf), 32'd0);
`else
      step(1'b0, 1'b0, 1'b0, '0);
`endif
      $display("seq reset: usedw=%0d empty=%b", usedw, empty);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
